// File: rtl/block_header_ctrl_pkg.sv
// Shared types for the block header controller: block geometry, FSM states,
// the registered header/residual record and the range-to-width helper.
package block_header_ctrl_pkg;

    localparam int BEATS_PER_BLOCK = 8;
    localparam int PIX_PER_BEAT    = 4;
    localparam int PIX_PER_BLOCK   = 32;
    localparam int BEAT_W          = PIX_PER_BEAT * 32;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [PIX_PER_BLOCK-1:0][31:0] pixels;
        logic [7:0] min_r;
        logic [7:0] min_g;
        logic [7:0] min_b;
        logic [7:0] min_a;
        logic [7:0] max_r;
        logic [7:0] max_g;
        logic [7:0] max_b;
        logic [7:0] max_a;
        logic       skip_r;
        logic       skip_g;
        logic       skip_b;
        logic       skip_a;
        logic [3:0] bits_required;
        logic       compressable;
    } header_residual_reg;

    // Number of bits needed to code a channel range: msb index + 1, 0 for a flat channel.
    function automatic logic [3:0] width_from_range(input logic [7:0] rng);
        logic [3:0] w;
        w = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (rng[i]) w = 4'(i + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/block_header_ctrl_if.sv
// Pixel-beat input stream and finished-block output of the header controller.
interface block_header_ctrl_if;
    import block_header_ctrl_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [BEAT_W-1:0]     in_pixels;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    header_residual_reg    out_hr;
    logic                  busy;
    logic [15:0]           blocks_done;

    modport master (
        output in_valid, in_pixels, flush, out_ready,
        input  in_ready, out_valid, out_hr, busy, blocks_done
    );

    modport slave (
        input  in_valid, in_pixels, flush, out_ready,
        output in_ready, out_valid, out_hr, busy, blocks_done
    );
endinterface

// File: rtl/block_header_ctrl_minmax.sv
// Combinational min/max header unit over one 32-pixel block. Skip, width and
// compressable fields are left as zero placeholders for the caller to fill.
module block_header_ctrl_minmax
    import block_header_ctrl_pkg::*;
(
    input  logic [PIX_PER_BLOCK-1:0][31:0] pixels,
    output header_residual_reg             hr
);

    logic [3:0][7:0] mn;
    logic [3:0][7:0] mx;

    // Per-channel running min/max across all pixels of the block.
    always_comb begin
        mn = '1;
        mx = '0;
        for (int p = 0; p < PIX_PER_BLOCK; p++) begin
            for (int j = 0; j < 4; j++) begin
                if (pixels[p][8*j +: 8] < mn[j]) mn[j] = pixels[p][8*j +: 8];
                if (pixels[p][8*j +: 8] > mx[j]) mx[j] = pixels[p][8*j +: 8];
            end
        end
    end

    // Pack results into the header record.
    always_comb begin
        hr               = '0;
        hr.pixels        = pixels;
        hr.min_r         = mn[0];
        hr.min_g         = mn[1];
        hr.min_b         = mn[2];
        hr.min_a         = mn[3];
        hr.max_r         = mx[0];
        hr.max_g         = mx[1];
        hr.max_b         = mx[2];
        hr.max_a         = mx[3];
    end

endmodule

// File: rtl/block_header_ctrl.sv
// Collects 8 beats of 4 pixels into a block, computes its header in one CALC
// cycle and holds the registered result until the downstream accepts it.
//
// state | meaning
// FILL  | accepting beats into the pixel buffer
// CALC  | one cycle: register min/max header and derived fields
// OUT   | out_hr presented, waiting for out_ready
module block_header_ctrl
    import block_header_ctrl_pkg::*;
#(
    parameter int BEATS_PER_BLOCK = block_header_ctrl_pkg::BEATS_PER_BLOCK,
    parameter int PIX_PER_BEAT    = block_header_ctrl_pkg::PIX_PER_BEAT
) (
    input  logic                     clk,
    input  logic                     rst,
    block_header_ctrl_if.slave       bus
);

    localparam int CNT_W = (BEATS_PER_BLOCK > 1) ? $clog2(BEATS_PER_BLOCK) : 1;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [PIX_PER_BLOCK-1:0][31:0]  pix_buf_q, pix_buf_d;
    header_residual_reg              out_hr_q, out_hr_d;
    logic [15:0]                     blocks_done_q, blocks_done_d;

    header_residual_reg              hr_calc;
    logic [7:0]                      rng_r, rng_g, rng_b, rng_a;
    logic [3:0]                      w_r, w_g, w_b, w_a;
    logic [3:0]                      bits_req;
    logic [4:0]                      pix_idx;

    block_header_ctrl_minmax u_minmax (
        .pixels (pix_buf_q),
        .hr     (hr_calc)
    );

    // Channel ranges and coded widths; max >= min by construction so no underflow.
    always_comb begin
        rng_r    = hr_calc.max_r - hr_calc.min_r;
        rng_g    = hr_calc.max_g - hr_calc.min_g;
        rng_b    = hr_calc.max_b - hr_calc.min_b;
        rng_a    = hr_calc.max_a - hr_calc.min_a;
        w_r      = width_from_range(rng_r);
        w_g      = width_from_range(rng_g);
        w_b      = width_from_range(rng_b);
        w_a      = width_from_range(rng_a);
        bits_req = w_r;
        if (w_g > bits_req) bits_req = w_g;
        if (w_b > bits_req) bits_req = w_b;
        if (w_a > bits_req) bits_req = w_a;
    end

    // Next-state, beat buffering, header capture and handoff counting.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pix_buf_d     = pix_buf_q;
        out_hr_d      = out_hr_q;
        blocks_done_d = blocks_done_q;
        pix_idx       = '0;
        unique case (state_q)
            ST_FILL: begin
                if (bus.flush) begin
                    cnt_d = '0;
                end else if (bus.in_valid) begin
                    for (int k = 0; k < PIX_PER_BEAT; k++) begin
                        pix_idx = 5'(32'(cnt_q) * PIX_PER_BEAT + k);
                        pix_buf_d[pix_idx] = bus.in_pixels[32*k +: 32];
                    end
                    if (cnt_q == CNT_W'(BEATS_PER_BLOCK - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_CALC: begin
                out_hr_d               = hr_calc;
                out_hr_d.skip_r        = (rng_r == 8'd0);
                out_hr_d.skip_g        = (rng_g == 8'd0);
                out_hr_d.skip_b        = (rng_b == 8'd0);
                out_hr_d.skip_a        = (rng_a == 8'd0);
                out_hr_d.bits_required = bits_req;
                out_hr_d.compressable  = (bits_req < 4'd8);
                state_d                = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d       = ST_FILL;
                    blocks_done_d = blocks_done_q + 16'd1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FILL;
            cnt_q         <= '0;
            out_hr_q      <= '0;
            blocks_done_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_hr_q      <= out_hr_d;
            blocks_done_q <= blocks_done_d;
        end
    end

    // Pixel buffer is never read before being refilled, so it carries no reset.
    always_ff @(posedge clk) begin
        pix_buf_q <= pix_buf_d;
    end

    assign bus.in_ready    = (state_q == ST_FILL);
    assign bus.out_valid   = (state_q == ST_OUT);
    assign bus.out_hr      = out_hr_q;
    assign bus.busy        = (state_q != ST_FILL) || (cnt_q != '0);
    assign bus.blocks_done = blocks_done_q;

endmodule
